// File: rtl/y_sram_mp_if.sv
// Access bus of the Y scratch memory: one masked write port, two read ports
// and the clear/ready handshake.
interface y_sram_mp_if #(
  parameter int DATA_W = 256,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 11
);
  localparam int MASK_W = DATA_W / LANE_W;

  logic              init_start;
  logic              ready;
  logic              WE;
  logic [ADDR_W-1:0] WriteAddress;
  logic [MASK_W-1:0] WriteMask;
  logic [DATA_W-1:0] WriteBus;
  logic              RE1;
  logic [ADDR_W-1:0] ReadAddress1;
  logic [DATA_W-1:0] ReadBus1;
  logic              ReadValid1;
  logic              ReadErr1;
  logic              RE2;
  logic [ADDR_W-1:0] ReadAddress2;
  logic [DATA_W-1:0] ReadBus2;
  logic              ReadValid2;
  logic              ReadErr2;

  modport master (
    output init_start, WE, WriteAddress, WriteMask, WriteBus,
    output RE1, ReadAddress1, RE2, ReadAddress2,
    input  ready, ReadBus1, ReadValid1, ReadErr1, ReadBus2, ReadValid2, ReadErr2
  );

  modport slave (
    input  init_start, WE, WriteAddress, WriteMask, WriteBus,
    input  RE1, ReadAddress1, RE2, ReadAddress2,
    output ready, ReadBus1, ReadValid1, ReadErr1, ReadBus2, ReadValid2, ReadErr2
  );
endinterface

// File: rtl/y_sram_mp.sv
// Y scratch memory: 1W/2R array with lane-masked writes, write-to-read
// forwarding, out-of-range flags and a zero-fill clear engine.
module y_sram_mp_lane #(
  parameter int LANE_W = 32
) (
  input  logic              sel,
  input  logic [LANE_W-1:0] newData,
  input  logic [LANE_W-1:0] oldData,
  output logic [LANE_W-1:0] mergedData
);
  assign mergedData = sel ? newData : oldData;
endmodule

module y_sram_mp #(
  parameter int DATA_W = 256,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input logic   clock,
  input logic   reset_n,
  y_sram_mp_if.slave bus
);
  localparam int MASK_W    = DATA_W / LANE_W;
  localparam int NUM_PORTS = 2;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, nextState;
  logic [ADDR_W-1:0] clearPtr, nextPtr;
  logic              rdy, accessOk;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clearPtr <= '0;
    end else begin
      state    <= nextState;
      clearPtr <= nextPtr;
    end
  end

  always_comb begin
    nextState = state;
    nextPtr   = clearPtr;
    rdy       = 1'b0;
    case (state)
      CLEAR: begin
        if (bus.init_start) nextPtr = '0;
        else if (clearPtr == LAST) begin
          nextState = READY;
          nextPtr   = '0;
        end else nextPtr = clearPtr + 1'b1;
      end
      READY: begin
        rdy = 1'b1;
        if (bus.init_start) begin
          nextState = CLEAR;
          nextPtr   = '0;
        end
      end
      default: nextState = CLEAR;
    endcase
  end

  assign bus.ready = rdy;
  // init_start wins over any access presented in the same cycle
  assign accessOk = rdy & ~bus.init_start;

  logic [DATA_W-1:0] mem [DEPTH];

  logic                          wrInRange, wrAcc;
  logic [ADDR_W-1:0]             wrIdx;
  logic [MASK_W-1:0][LANE_W-1:0] oldWord, mergedWord;

  assign wrInRange = {1'b0, bus.WriteAddress} < DEPTH_X;
  assign wrIdx     = wrInRange ? bus.WriteAddress : '0;
  assign wrAcc     = accessOk & bus.WE & wrInRange;
  assign oldWord   = mem[wrIdx];

  // merged word feeds both the array write and same-address read forwarding
  for (genvar l = 0; l < MASK_W; l++) begin : gLane
    y_sram_mp_lane #(.LANE_W(LANE_W)) uLane (
      .sel        (bus.WriteMask[l]),
      .newData    (bus.WriteBus[l*LANE_W +: LANE_W]),
      .oldData    (oldWord[l]),
      .mergedData (mergedWord[l])
    );
  end

  always_ff @(posedge clock) begin
    if (state == CLEAR) mem[clearPtr] <= '0;
    else if (wrAcc)     mem[wrIdx]    <= mergedWord;
  end

  logic [NUM_PORTS-1:0]             re, rdInRange, rdAcc, rdFwd;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] rdAddr, rdIdx;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdWord, rdBus;
  logic [NUM_PORTS-1:0]             rdValid, rdErr;

  assign re     = {bus.RE2, bus.RE1};
  assign rdAddr = {bus.ReadAddress2, bus.ReadAddress1};

  always_comb begin
    rdInRange = '0;
    rdIdx     = '0;
    rdAcc     = '0;
    rdFwd     = '0;
    rdWord    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rdInRange[p] = {1'b0, rdAddr[p]} < DEPTH_X;
      rdIdx[p]     = rdInRange[p] ? rdAddr[p] : '0;
      rdAcc[p]     = accessOk & re[p];
      rdFwd[p]     = wrAcc & (bus.WriteAddress == rdAddr[p]);
      if (!rdInRange[p]) rdWord[p] = '0;
      else if (rdFwd[p]) rdWord[p] = mergedWord;
      else               rdWord[p] = mem[rdIdx[p]];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdBus   <= '0;
      rdValid <= '0;
      rdErr   <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rdValid[p] <= rdAcc[p];
        rdErr[p]   <= rdAcc[p] & ~rdInRange[p];
        if (rdAcc[p]) rdBus[p] <= rdWord[p];
      end
    end
  end

  assign bus.ReadBus1   = rdBus[0];
  assign bus.ReadValid1 = rdValid[0];
  assign bus.ReadErr1   = rdErr[0];
  assign bus.ReadBus2   = rdBus[1];
  assign bus.ReadValid2 = rdValid[1];
  assign bus.ReadErr2   = rdErr[1];
endmodule

// File: tb/tb_y_sram_mp.sv
// Scoreboard bench for y_sram_mp: main instance DEPTH=12/ADDR_W=4, plus a
// full-depth DEPTH=16 instance for clear timing and the no-error case.
module tb_y_sram_mp;
  localparam int DATA_W = 256;
  localparam int LANE_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;
  localparam int MASK_W = DATA_W / LANE_W;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  y_sram_mp_if #(.DATA_W(DATA_W), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) bus ();
  y_sram_mp_if #(.DATA_W(DATA_W), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) bus16 ();

  y_sram_mp #(.DATA_W(DATA_W), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave));
  y_sram_mp #(.DATA_W(DATA_W), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .DEPTH(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .bus(bus16.slave));

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t q1[$], q2[$];
  exp_t e1, e2;
  logic [DATA_W-1:0] mdl [DEPTH];
  int checks = 0;
  int errors = 0;

  function automatic logic [DATA_W-1:0] mergeW(input logic [DATA_W-1:0] o, input logic [DATA_W-1:0] n,
                                                input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    for (int l = 0; l < MASK_W; l++)
      r[l*LANE_W +: LANE_W] = m[l] ? n[l*LANE_W +: LANE_W] : o[l*LANE_W +: LANE_W];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rndWord();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W/32; i++) w[i*32 +: 32] = $urandom;
    return w | 1;
  endfunction

  // scoreboard pop: every read strobe must match the oldest pending expectation
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.ReadValid1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL rd1_unexpected got data=%h err=%b", bus.ReadBus1, bus.ReadErr1);
        end else begin
          e1 = q1.pop_front();
          if ({bus.ReadBus1, bus.ReadErr1} !== {e1.data, e1.err}) begin
            errors++;
            $display("FAIL rd1_data got %h/%b exp %h/%b", bus.ReadBus1, bus.ReadErr1, e1.data, e1.err);
          end
        end
      end
      if (bus.ReadValid2) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL rd2_unexpected got data=%h err=%b", bus.ReadBus2, bus.ReadErr2);
        end else begin
          e2 = q2.pop_front();
          if ({bus.ReadBus2, bus.ReadErr2} !== {e2.data, e2.err}) begin
            errors++;
            $display("FAIL rd2_data got %h/%b exp %h/%b", bus.ReadBus2, bus.ReadErr2, e2.data, e2.err);
          end
        end
      end
    end
  end

  task automatic idle();
    bus.init_start = 1'b0; bus.WE = 1'b0; bus.WriteAddress = '0; bus.WriteMask = '0;
    bus.WriteBus = '0; bus.RE1 = 1'b0; bus.ReadAddress1 = '0; bus.RE2 = 1'b0; bus.ReadAddress2 = '0;
  endtask

  task automatic idle16();
    bus16.init_start = 1'b0; bus16.WE = 1'b0; bus16.WriteAddress = '0; bus16.WriteMask = '0;
    bus16.WriteBus = '0; bus16.RE1 = 1'b0; bus16.ReadAddress1 = '0; bus16.RE2 = 1'b0;
    bus16.ReadAddress2 = '0;
  endtask

  // one accepted-access cycle; called at a negedge, returns at the next negedge
  task automatic step(input logic we, input int wa, input logic [MASK_W-1:0] wm,
                      input logic [DATA_W-1:0] wd, input logic r1, input int a1,
                      input logic r2, input int a2);
    logic wrOk;
    logic [DATA_W-1:0] mw;
    exp_t e;
    wrOk = we && (wa < DEPTH);
    mw = wrOk ? mergeW(mdl[wa], wd, wm) : '0;
    bus.WE = we; bus.WriteAddress = wa[ADDR_W-1:0]; bus.WriteMask = wm; bus.WriteBus = wd;
    bus.RE1 = r1; bus.ReadAddress1 = a1[ADDR_W-1:0];
    bus.RE2 = r2; bus.ReadAddress2 = a2[ADDR_W-1:0];
    if (r1) begin
      if (a1 >= DEPTH) begin e.data = '0; e.err = 1'b1; end
      else begin e.data = (wrOk && wa == a1) ? mw : mdl[a1]; e.err = 1'b0; end
      q1.push_back(e);
    end
    if (r2) begin
      if (a2 >= DEPTH) begin e.data = '0; e.err = 1'b1; end
      else begin e.data = (wrOk && wa == a2) ? mw : mdl[a2]; e.err = 1'b0; end
      q2.push_back(e);
    end
    if (wrOk) mdl[wa] = mw;
    @(posedge clock);
    @(negedge clock);
    idle();
  endtask

  task automatic drain(input string name);
    repeat (2) @(negedge clock);
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got q1=%0d q2=%0d exp 0/0", name, q1.size(), q2.size());
    end
  endtask

  // negedges counted until ready is seen high (999 on timeout)
  task automatic waitReady(output int n);
    n = 999;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if (bus.ready) begin n = k; break; end
    end
  endtask

  task automatic fillAll();
    for (int a = 0; a < DEPTH; a++) step(1, a, '1, rndWord(), 0, 0, 0, 0);
  endtask

  task automatic readAll(input string name);
    for (int a = 0; a < DEPTH; a++) step(0, 0, '0, '0, 1, a, 1, DEPTH - 1 - a);
    drain(name);
  endtask

  task automatic test_reset();
    checks++;
    if (bus.ready !== 1'b0 || bus.ReadValid1 !== 1'b0 || bus.ReadValid2 !== 1'b0 ||
        bus.ReadErr1 !== 1'b0 || bus.ReadErr2 !== 1'b0 || bus.ReadBus1 !== '0 || bus.ReadBus2 !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b%b e=%b%b", bus.ready, bus.ReadValid1, bus.ReadValid2,
               bus.ReadErr1, bus.ReadErr2);
    end
  endtask

  task automatic test_clear_timing();
    int n12, n16;
    n12 = 0; n16 = 0;
    reset_n = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (bus.ready && n12 == 0) n12 = k;
      if (bus16.ready && n16 == 0) n16 = k;
      if (n12 != 0 && n16 != 0) break;
    end
    checks++;
    if (n12 != DEPTH) begin errors++; $display("FAIL clear_time12 got %0d exp %0d", n12, DEPTH); end
    checks++;
    if (n16 != 16) begin errors++; $display("FAIL clear_time16 got %0d exp 16", n16); end
    readAll("clear_zero");
    // full-depth instance: top address is in range, never flagged
    bus16.RE1 = 1'b1; bus16.ReadAddress1 = 4'd15;
    @(posedge clock); @(negedge clock);
    bus16.RE1 = 1'b0;
    checks++;
    if (bus16.ReadValid1 !== 1'b1 || bus16.ReadErr1 !== 1'b0 || bus16.ReadBus1 !== '0) begin
      errors++;
      $display("FAIL full_depth_read got v=%b e=%b d=%h exp 1/0/0", bus16.ReadValid1, bus16.ReadErr1,
               bus16.ReadBus1);
    end
    @(negedge clock);
    checks++;
    if (bus16.ReadValid1 !== 1'b0) begin
      errors++; $display("FAIL valid_one_cycle got %b exp 0", bus16.ReadValid1);
    end
  endtask

  task automatic test_masked_write();
    step(1, 5, '1, '1, 0, 0, 0, 0);
    step(1, 5, 8'h01, '0, 0, 0, 0, 0);
    step(1, 6, 8'h00, '0, 0, 0, 0, 0);
    step(0, 0, '0, '0, 1, 5, 1, 6);
    drain("masked_write");
  endtask

  task automatic test_forwarding();
    logic [DATA_W-1:0] a, f;
    a = {(DATA_W/8){8'hAA}};
    f = {(DATA_W/8){8'h55}};
    step(1, 3, '1, a, 0, 0, 0, 0);
    step(1, 3, 8'hF0, f, 1, 3, 1, 3);
    step(0, 0, '0, '0, 1, 3, 0, 0);
    drain("forwarding");
  endtask

  task automatic test_dual_port();
    step(1, 2, '1, rndWord(), 0, 0, 0, 0);
    step(1, 7, '1, rndWord(), 0, 0, 0, 0);
    step(1, 9, '1, rndWord(), 0, 0, 0, 0);
    step(0, 0, '0, '0, 1, 2, 1, 2);
    step(0, 0, '0, '0, 1, 7, 1, 9);
    drain("dual_port");
  endtask

  task automatic test_out_of_range();
    fillAll();
    step(1, 13, '1, '1, 0, 0, 0, 0);
    step(0, 0, '0, '0, 1, 12, 1, 13);
    step(1, 15, '1, '1, 1, 15, 1, 0);
    readAll("out_of_range");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), $urandom_range(0, 15), MASK_W'($urandom), rndWord(),
           $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15));
    drain("back_to_back");
  endtask

  task automatic test_init_start();
    int n;
    fillAll();
    // init_start together with accesses: all of them must be dropped
    bus.init_start = 1'b1; bus.WE = 1'b1; bus.WriteAddress = 4'd4; bus.WriteMask = '1;
    bus.WriteBus = '1; bus.RE1 = 1'b1; bus.ReadAddress1 = 4'd4; bus.RE2 = 1'b1; bus.ReadAddress2 = 4'd5;
    @(posedge clock); #1 idle();
    waitReady(n);
    checks++;
    if (n != DEPTH + 1) begin errors++; $display("FAIL init_time got %0d exp %0d", n, DEPTH + 1); end
    for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
    readAll("init_zero");
    // init_start during clear restarts the pointer
    fillAll();
    bus.init_start = 1'b1;
    @(posedge clock); #1 idle();
    repeat (4) @(negedge clock);
    bus.init_start = 1'b1;
    @(posedge clock); #1 idle();
    waitReady(n);
    checks++;
    if (n != DEPTH + 1) begin errors++; $display("FAIL init_restart got %0d exp %0d", n, DEPTH + 1); end
    for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
    readAll("restart_zero");
  endtask

  task automatic test_reset_mid();
    int n;
    fillAll();
    step(0, 0, '0, '0, 1, 1, 0, 0);
    bus.init_start = 1'b1;
    @(posedge clock); #1 idle();
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.ReadBus1 !== '0 || bus.ReadValid1 !== 1'b0 || bus.ReadErr1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b d=%h v=%b", bus.ready, bus.ReadBus1, bus.ReadValid1);
    end
    @(negedge clock);
    reset_n = 1'b1;
    waitReady(n);
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL reset_mid_time got %0d exp %0d", n, DEPTH); end
    for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
    readAll("reset_mid_zero");
  endtask

  initial begin
    idle();
    idle16();
    for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
    repeat (3) @(negedge clock);
    test_reset();
    test_clear_timing();
    test_masked_write();
    test_forwarding();
    test_dual_port();
    test_out_of_range();
    test_back_to_back();
    test_init_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/y_sram_mp.md
Name: y_sram_mp

Overview:
- Parametrised successor to the fixed 256-bit, 2048-entry Y scratch memory: one write port, two independent read ports.
- Adds lane-masked writes, registered reads with valid strobes, write-to-read forwarding, out-of-range detection, and a hardware clear engine that zero-fills the array after reset or on request.
- Sits between the Y-integration datapath and the storage array; consumers must wait for ready.

Parameters:
- DATA_W, 256, word width in bits; must be a multiple of LANE_W.
- LANE_W, 32, write-mask granularity in bits; MASK_W = DATA_W/LANE_W.
- ADDR_W, 11, address width.
- DEPTH, 2048, number of words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- init_start  in  1  request a full zero-fill; single-cycle pulse.
- ready  out  1  high when the array is open for accesses.
- WE  in  1  write enable.
- WriteAddress  in  ADDR_W  write address.
- WriteMask  in  MASK_W  bit i enables lane i, i.e. bits [i*LANE_W +: LANE_W].
- WriteBus  in  DATA_W  write data.
- RE1  in  1  read request, port 1.
- ReadAddress1  in  ADDR_W  read address, port 1.
- ReadBus1  out  DATA_W  registered read data, port 1.
- ReadValid1  out  1  one-cycle strobe: ReadBus1 is new.
- ReadErr1  out  1  qualifies ReadValid1: address was >= DEPTH.
- RE2, ReadAddress2, ReadBus2, ReadValid2, ReadErr2: same as port 1, for port 2.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=CLEAR, clear_ptr=0, ready=0.
  - ReadBus1/2=0, ReadValid1/2=0, ReadErr1/2=0.
  - Array contents are not reset directly; the clear engine zero-fills them.
- FSM states: CLEAR and READY.
- CLEAR state:
  - Each cycle writes all-zero to mem[clear_ptr], then clear_ptr++.
  - After the write to DEPTH-1, the next state is READY, so ready rises exactly DEPTH cycles after reset deasserts.
  - WE/RE are ignored; ReadValid stays 0.
  - init_start during CLEAR restarts clear_ptr at 0.
- READY state:
  - init_start=1 -> next state CLEAR with clear_ptr=0 and ready=0 the next cycle.
  - Any WE/RE presented in that same cycle is dropped; init_start has priority.
- Write, when ready & WE & WriteAddress<DEPTH:
  - Lanes with mask bit set are updated at the edge; other lanes keep their value.
  - WriteMask=0 is a no-op.
  - WriteAddress>=DEPTH: write silently dropped.
- Read, when ready & REn:
  - Latency 1: the next cycle ReadBusn = mem[ReadAddressn], ReadValidn=1.
  - ReadValidn is 0 in any cycle without an accepted read.
  - ReadBusn holds its last value when no read is accepted.
- Read port independence:
  - Both ports may read the same or different addresses in the same cycle.
  - The ports never conflict with each other.
- Forwarding: if WE is accepted in the same cycle and WriteAddress==ReadAddressn (in range), ReadBusn returns the merged word: masked lanes from WriteBus, unmasked lanes from old contents.
- Out of range: ReadAddressn>=DEPTH -> ReadBusn=0, ReadValidn=1, ReadErrn=1 for that one cycle. ReadErrn is 0 otherwise.
- Reset mid-operation: state, pointer and outputs return to reset values immediately, and a new clear begins when reset_n rises.
- In-range accesses must never index beyond DEPTH-1.
- If DEPTH==2**ADDR_W, ReadErr is always 0.

Test Plan:
- Clear timing (DEPTH=16): release reset_n -> ready=0 for exactly 16 cycles, then 1; RE1 at addresses 0..15 -> ReadBus1=0 with ReadValid1=1 one cycle after each request.
- Masked write: write 0xFFFF..FF to addr 5, then WE with WriteMask=0x01, WriteBus=0 -> read addr 5 returns lane0=0, lanes1..7=0xFFFFFFFF.
- Forwarding: mem[3]=0xAAAA..AA; same cycle WE addr 3, mask 0xF0, data 0x5555..55, with RE1 addr 3 -> ReadBus1 lanes7..4=0x55555555, lanes3..0=0xAAAAAAAA.
- Dual-port: RE1 addr 2 and RE2 addr 2, then RE1 addr 7 and RE2 addr 9 -> both ports return correct data with ReadValid1=ReadValid2=1 each cycle.
- Out of range (DEPTH=12, ADDR_W=4): WE addr 13, then RE2 addr 13 -> ReadBus2=0, ReadValid2=1, ReadErr2=1; addr 0..11 contents unchanged.
- init_start mid-stream: with all words nonzero, pulse init_start together with WE -> write dropped, ready=0 for DEPTH cycles, then all reads return 0; reset_n pulsed mid-clear -> clear restarts from 0.
